rv32e_exec_units: RTL and testbench
===================================

// Module: rv32e_exec_units
// PURPOSE
//  Integer datapath for the RV32E 5-stage core: a 16x32 register file and a combinational ALU.
//  The regfile serves ID reads and WB writes; the ALU computes results and flags in EX.
//  Used for arithmetic, address generation and branch compare.
// PARAMETERS
//  XLEN     32  datapath width (fixed, not overridable in practice)
//  NREGS    16  architectural registers x0..x15 (RV32E)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   reset, asynchronous, active-low
//  rs1_addr       in   4   read port 1 address
//  rs2_addr       in   4   read port 2 address
//  rs1_data       out  32  read port 1 data (combinational)
//  rs2_data       out  32  read port 2 data (combinational)
//  rd_addr        in   4   write address
//  rd_data        in   32  write data
//  rd_we          in   1   write enable
//  alu_op         in   4   operation select
//  alu_a          in   32  operand A
//  alu_b          in   32  operand B
//  alu_result     out 32  ALU result (combinational)
//  zero_flag      out  1   alu_result == 0
//  negative_flag  out  1   alu_result[31]
//  overflow_flag  out  1   signed overflow of ADD/SUB, else 0
// BEHAVIOUR
//  Regfile:
//  - rst_n low clears x0..x15 to 0 immediately, independent of clk.
//  - While in reset, rs*_data read 0.
//  - Write on rising clk when rd_we=1 and rd_addr!=0.
//  - Writes to x0 are ignored; x0 always reads 0.
//  - Reads are combinational.
//  - Write-through bypass: if rd_we=1, rd_addr!=0 and rd_addr==rsN_addr, rsN_data=rd_data
//    in the same cycle. This covers WB->ID with no stall.
//  - Both ports may read the same register; the result is identical on both.
//  ALU, purely combinational, zero latency:
//  - 0000 ADD   a+b, mod 2^32
//  - 1000 SUB   a-b
//  - 0001 SLL   a << b[4:0]
//  - 0010 SLT   {31'b0, $signed(a) < $signed(b)}
//  - 0011 SLTU  {31'b0, a < b}
//  - 0100 XOR
//  - 0101 SRL   logical a >> b[4:0]
//  - 1101 SRA   arithmetic a >>> b[4:0]
//  - 0110 OR
//  - 0111 AND
//  - 1001,1010,1011,1100,1110,1111: branch compares, which compute SUB a-b so the flags
//    give equality and sign.
//  - Shift amounts use only b[4:0]; b[31:5] is ignored.
//  - overflow_flag: ADD is (a[31]==b[31]) && (r[31]!=a[31]); SUB is (a[31]!=b[31]) &&
//    (r[31]!=a[31]). It is 0 for every other op.
//  - zero_flag and negative_flag are derived from alu_result for every op.
//  - No undefined ops exist: every 4-bit code decodes.
// STRUCTURE
//  - Shared package rv32e_pkg holds:
//    - localparams ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
//      ALU_OR, ALU_AND
//    - REG_ADDR_W=4, XLEN=32.
//  - Sub-module rv32e_alu_core: the combinational ALU.
//  - The regfile array, reset, bypass and x0 logic live in the top.
// TESTING
//  - Reset/x0:
//    - pulse rst_n low mid-run -> all reads 0 with no clk edge.
//    - write x0=0xDEADBEEF -> x0 still reads 0.
//  - Write/read and bypass:
//    - rd_we=1, rd=5, data 0x12345678, rs1=5 -> rs1_data=0x12345678 in the same cycle.
//    - After the edge with rd_we=0 -> still 0x12345678.
//  - Arithmetic:
//    - ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1, neg=1.
//    - SUB 5-5 -> 0, zero=1.
//    - ADD 0xFFFFFFFF+1 -> 0, zero=1, overflow=0.
//  - Shifts: SLL 1<<35 -> 8; SRL 0x80000000>>4 -> 0x08000000; SRA 0x80000000>>4 -> 0xF8000000.
//  - Compares: SLT -1<1 -> 1; SLTU 0xFFFFFFFF<1 -> 0.
//  - Logic: AND/OR/XOR on 0xF0F0F0F0/0x0FF00FF0 -> 0x00F000F0 / 0xFFF0FFF0 / 0xFF00FF00.
//  - Branch op 1001 with a=b=7 -> result 0, zero=1.

Source files
------------

// File: rtl/rv32e_pkg.sv
// Shared constants for the RV32E integer datapath: widths and ALU operation encodings.
package rv32e_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 4;
  localparam int NREGS      = 16;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // Branch-compare codes reuse the subtractor, so they share SUB's overflow rule.
  function automatic logic is_sub_class(input logic [3:0] op);
    logic res;
    case (op)
      4'b1000, 4'b1001, 4'b1010, 4'b1011,
      4'b1100, 4'b1110, 4'b1111: res = 1'b1;
      default:                   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rv32e_alu_core.sv
// Combinational RV32E ALU: result plus zero/negative/overflow flags, zero latency.
module rv32e_alu_core
  import rv32e_pkg::*;
(
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  output logic [XLEN-1:0] alu_result,
  output logic            zero_flag,
  output logic            negative_flag,
  output logic            overflow_flag
);

  logic [XLEN-1:0] sum_s;
  logic [XLEN-1:0] diff_s;
  logic [4:0]      shamt_s;
  logic            slt_s;
  logic            sltu_s;
  logic [XLEN-1:0] result_s;
  logic            overflow_s;

  assign sum_s   = alu_a + alu_b;
  assign diff_s  = alu_a - alu_b;
  assign shamt_s = alu_b[4:0];
  assign slt_s   = $signed(alu_a) < $signed(alu_b);
  assign sltu_s  = alu_a < alu_b;

  // Operation select; every code not listed is a branch compare and yields a-b.
  always_comb begin
    result_s = diff_s;
    case (alu_op)
      ALU_ADD:  result_s = sum_s;
      ALU_SUB:  result_s = diff_s;
      ALU_SLL:  result_s = alu_a << shamt_s;
      ALU_SLT:  result_s = {{(XLEN-1){1'b0}}, slt_s};
      ALU_SLTU: result_s = {{(XLEN-1){1'b0}}, sltu_s};
      ALU_XOR:  result_s = alu_a ^ alu_b;
      ALU_SRL:  result_s = alu_a >> shamt_s;
      ALU_SRA:  result_s = $unsigned($signed(alu_a) >>> shamt_s);
      ALU_OR:   result_s = alu_a | alu_b;
      ALU_AND:  result_s = alu_a & alu_b;
      default:  result_s = diff_s;
    endcase
  end

  // Signed overflow only for the adder and the subtractor-based ops.
  always_comb begin
    overflow_s = 1'b0;
    if (alu_op == ALU_ADD) begin
      overflow_s = (alu_a[XLEN-1] == alu_b[XLEN-1]) && (sum_s[XLEN-1] != alu_a[XLEN-1]);
    end else if (is_sub_class(alu_op)) begin
      overflow_s = (alu_a[XLEN-1] != alu_b[XLEN-1]) && (diff_s[XLEN-1] != alu_a[XLEN-1]);
    end else begin
      overflow_s = 1'b0;
    end
  end

  assign alu_result    = result_s;
  assign zero_flag     = (result_s == {XLEN{1'b0}});
  assign negative_flag = result_s[XLEN-1];
  assign overflow_flag = overflow_s;

endmodule

// File: rtl/rv32e_exec_units.sv
// RV32E integer datapath: 16x32 register file with write-through bypass, plus the EX ALU.
module rv32e_exec_units
  import rv32e_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]       rd_data,
  input  logic                  rd_we,
  input  logic [3:0]            alu_op,
  input  logic [XLEN-1:0]       alu_a,
  input  logic [XLEN-1:0]       alu_b,
  output logic [XLEN-1:0]       alu_result,
  output logic                  zero_flag,
  output logic                  negative_flag,
  output logic                  overflow_flag
);

  logic [XLEN-1:0] regs_r [NREGS];
  logic            wr_en_s;
  logic [XLEN-1:0] rs1_data_s;
  logic [XLEN-1:0] rs2_data_s;

  assign wr_en_s = rd_we && (rd_addr != {REG_ADDR_W{1'b0}});

  // Register array: async clear, x0 never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[rd_addr] <= rd_data;
    end
  end

  // Read port 1: forced zero in reset, WB bypass, then x0 and array lookup.
  always_comb begin
    rs1_data_s = {XLEN{1'b0}};
    if (!rst_n) begin
      rs1_data_s = {XLEN{1'b0}};
    end else if (wr_en_s && (rd_addr == rs1_addr)) begin
      rs1_data_s = rd_data;
    end else if (rs1_addr == {REG_ADDR_W{1'b0}}) begin
      rs1_data_s = {XLEN{1'b0}};
    end else begin
      rs1_data_s = regs_r[rs1_addr];
    end
  end

  // Read port 2: same priority as port 1 so both ports agree on a shared address.
  always_comb begin
    rs2_data_s = {XLEN{1'b0}};
    if (!rst_n) begin
      rs2_data_s = {XLEN{1'b0}};
    end else if (wr_en_s && (rd_addr == rs2_addr)) begin
      rs2_data_s = rd_data;
    end else if (rs2_addr == {REG_ADDR_W{1'b0}}) begin
      rs2_data_s = {XLEN{1'b0}};
    end else begin
      rs2_data_s = regs_r[rs2_addr];
    end
  end

  assign rs1_data = rs1_data_s;
  assign rs2_data = rs2_data_s;

  rv32e_alu_core u_alu (
    .alu_op        (alu_op),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_result    (alu_result),
    .zero_flag     (zero_flag),
    .negative_flag (negative_flag),
    .overflow_flag (overflow_flag)
  );

endmodule

// File: tb/tb_rv32e_exec_units.sv
// Directed self-checking bench for rv32e_exec_units: regfile reset/x0/bypass and ALU ops.
module tb_rv32e_exec_units;

  logic        clk;
  logic        rst_n;
  logic [3:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, rd_data;
  logic        rd_we;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        zero_flag, negative_flag, overflow_flag;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
    logic        n;
    logic        v;
  } vec_t;

  rv32e_exec_units dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_we         (rd_we),
    .alu_op        (alu_op),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_result    (alu_result),
    .zero_flag     (zero_flag),
    .negative_flag (negative_flag),
    .overflow_flag (overflow_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    rd_we = 1'b1; rd_addr = addr; rd_data = data;
    @(negedge clk);
    rd_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd_we = 1'b0; rd_addr = 4'd0; rd_data = 32'd0;
    rs1_addr = 4'd5; rs2_addr = 4'd9;
    alu_op = 4'b0000; alu_a = 32'd0; alu_b = 32'd0;
    #2;
    total++;
    if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_reads: rs1=%h rs2=%h expected 0 0", rs1_data, rs2_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_x0();
    do_write(4'd0, 32'hDEADBEEF);
    rs1_addr = 4'd0; rs2_addr = 4'd0;
    #1;
    total++;
    if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
      bad++;
      $display("FAIL x0_write_ignored: rs1=%h rs2=%h expected 0 0", rs1_data, rs2_data);
    end
    // x0 write in flight must not bypass either
    @(negedge clk);
    rd_we = 1'b1; rd_addr = 4'd0; rd_data = 32'hCAFEF00D;
    #1;
    total++;
    if (rs1_data !== 32'd0) begin
      bad++;
      $display("FAIL x0_no_bypass: rs1=%h expected 0", rs1_data);
    end
    @(negedge clk);
    rd_we = 1'b0;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    rd_we = 1'b1; rd_addr = 4'd5; rd_data = 32'h12345678;
    rs1_addr = 4'd5; rs2_addr = 4'd5;
    #1;
    total++;
    if (rs1_data !== 32'h12345678 || rs2_data !== 32'h12345678) begin
      bad++;
      $display("FAIL bypass_same_cycle: rs1=%h rs2=%h expected 12345678 12345678", rs1_data, rs2_data);
    end
    @(negedge clk);
    rd_we = 1'b0; rd_data = 32'h0;
    #1;
    total++;
    if (rs1_data !== 32'h12345678 || rs2_data !== 32'h12345678) begin
      bad++;
      $display("FAIL stored_after_edge: rs1=%h rs2=%h expected 12345678 12345678", rs1_data, rs2_data);
    end
  endtask

  task automatic test_two_regs();
    do_write(4'd3, 32'hAAAA0003);
    do_write(4'd15, 32'h5555000F);
    rs1_addr = 4'd3; rs2_addr = 4'd15;
    #1;
    total++;
    if (rs1_data !== 32'hAAAA0003 || rs2_data !== 32'h5555000F) begin
      bad++;
      $display("FAIL two_regs: rs1=%h rs2=%h expected aaaa0003 5555000f", rs1_data, rs2_data);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rd_we = 1'b1; rd_addr = 4'd3; rd_data = 32'h11111111;
    rs1_addr = 4'd3; rs2_addr = 4'd15;
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
      bad++;
      $display("FAIL async_reset_reads: rs1=%h rs2=%h expected 0 0", rs1_data, rs2_data);
    end
    rd_we = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    total++;
    if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
      bad++;
      $display("FAIL async_reset_cleared: rs1=%h rs2=%h expected 0 0", rs1_data, rs2_data);
    end
  endtask

  task automatic test_arith();
    vec_t v[4];
    v[0] = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b1};
    v[1] = '{4'b1000, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
    v[2] = '{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
    v[3] = '{4'b1000, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      alu_op = v[i].op; alu_a = v[i].a; alu_b = v[i].b;
      #1;
      total++;
      if (alu_result !== v[i].r || zero_flag !== v[i].z || negative_flag !== v[i].n || overflow_flag !== v[i].v) begin
        bad++;
        $display("FAIL arith[%0d]: r=%h z=%b n=%b v=%b expected %h %b %b %b", i,
                 alu_result, zero_flag, negative_flag, overflow_flag, v[i].r, v[i].z, v[i].n, v[i].v);
      end
    end
  endtask

  task automatic test_shifts();
    vec_t v[4];
    v[0] = '{4'b0001, 32'h00000001, 32'd35,       32'h00000008, 1'b0, 1'b0, 1'b0};
    v[1] = '{4'b0101, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, 1'b0};
    v[2] = '{4'b1101, 32'h80000000, 32'd4,        32'h F8000000, 1'b0, 1'b1, 1'b0};
    v[3] = '{4'b1101, 32'h40000000, 32'hFFFFFFE4, 32'h04000000, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      alu_op = v[i].op; alu_a = v[i].a; alu_b = v[i].b;
      #1;
      total++;
      if (alu_result !== v[i].r || zero_flag !== v[i].z || negative_flag !== v[i].n || overflow_flag !== v[i].v) begin
        bad++;
        $display("FAIL shift[%0d]: r=%h z=%b n=%b v=%b expected %h %b %b %b", i,
                 alu_result, zero_flag, negative_flag, overflow_flag, v[i].r, v[i].z, v[i].n, v[i].v);
      end
    end
  endtask

  task automatic test_compare_logic();
    vec_t v[5];
    v[0] = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
    v[1] = '{4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
    v[2] = '{4'b0111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0};
    v[3] = '{4'b0110, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b1, 1'b0};
    v[4] = '{4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      alu_op = v[i].op; alu_a = v[i].a; alu_b = v[i].b;
      #1;
      total++;
      if (alu_result !== v[i].r || zero_flag !== v[i].z || negative_flag !== v[i].n || overflow_flag !== v[i].v) begin
        bad++;
        $display("FAIL cmp_logic[%0d]: r=%h z=%b n=%b v=%b expected %h %b %b %b", i,
                 alu_result, zero_flag, negative_flag, overflow_flag, v[i].r, v[i].z, v[i].n, v[i].v);
      end
    end
  endtask

  task automatic test_branch();
    vec_t v[3];
    v[0] = '{4'b1001, 32'd7, 32'd7, 32'h00000000, 1'b1, 1'b0, 1'b0};
    v[1] = '{4'b1100, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0};
    v[2] = '{4'b1111, 32'd9, 32'd2, 32'h00000007, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      alu_op = v[i].op; alu_a = v[i].a; alu_b = v[i].b;
      #1;
      total++;
      if (alu_result !== v[i].r || zero_flag !== v[i].z || negative_flag !== v[i].n) begin
        bad++;
        $display("FAIL branch[%0d]: r=%h z=%b n=%b expected %h %b %b", i,
                 alu_result, zero_flag, negative_flag, v[i].r, v[i].z, v[i].n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_bypass();
    test_two_regs();
    test_async_reset();
    test_arith();
    test_shifts();
    test_compare_logic();
    test_branch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
